// File: rtl/crossbar_arbiter_if.sv
// Handshake bundle for the 2x2 crossbar arbiter: two request ports, two
// registered output ports, plus the crossbar select and conflict counter.
interface crossbar_arbiter_if;
    logic       in1_valid;
    logic       in1_dst;
    logic [3:0] in1_data;
    logic       in1_ready;
    logic       in2_valid;
    logic       in2_dst;
    logic [3:0] in2_data;
    logic       in2_ready;
    logic       out1_valid;
    logic [3:0] out1_data;
    logic       out1_ready;
    logic       out2_valid;
    logic [3:0] out2_data;
    logic       out2_ready;
    logic       xbar_control;
    logic [7:0] conflict_cnt;

    // The arbiter itself.
    modport slave (
        input  in1_valid, in1_dst, in1_data, in2_valid, in2_dst, in2_data,
        input  out1_ready, out2_ready,
        output in1_ready, in2_ready, out1_valid, out1_data, out2_valid, out2_data,
        output xbar_control, conflict_cnt
    );

    // Whatever drives the requests and consumes the outputs.
    modport master (
        output in1_valid, in1_dst, in1_data, in2_valid, in2_dst, in2_data,
        output out1_ready, out2_ready,
        input  in1_ready, in2_ready, out1_valid, out1_data, out2_valid, out2_data,
        input  xbar_control, conflict_cnt
    );
endinterface

// File: rtl/crossbar_arbiter.sv
// 2x2 crossbar arbiter: routes two 4-bit request ports onto two registered
// output slots, resolving same-destination conflicts with a round-robin bit.
module crossbar_arbiter (
    input  logic             clk,
    input  logic             rst_n,
    crossbar_arbiter_if.slave bus
);
    logic       out1_valid_q, out2_valid_q;
    logic [3:0] out1_data_q, out2_data_q;
    logic       rr;
    logic [7:0] cnt;

    logic       can1, can2;
    logic       grant1, grant2;
    logic       conflict_grant;
    logic       load1, load2;
    logic [3:0] load1_data, load2_data;

    // An output slot can take new data if it is empty or being drained now.
    assign can1 = !out1_valid_q || bus.out1_ready;
    assign can2 = !out2_valid_q || bus.out2_ready;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        grant1         = 1'b0;
        grant2         = 1'b0;
        conflict_grant = 1'b0;
        // Grants are held off while reset is asserted.
        if (rst_n) begin
            if (bus.in1_valid && bus.in2_valid && (bus.in1_dst == bus.in2_dst)) begin
                conflict_grant = bus.in1_dst ? can2 : can1;
                grant1         = conflict_grant && !rr;
                grant2         = conflict_grant && rr;
            end else begin
                grant1 = bus.in1_valid && (bus.in1_dst ? can2 : can1);
                grant2 = bus.in2_valid && (bus.in2_dst ? can2 : can1);
            end
        end
    end

    assign load1      = (grant1 && !bus.in1_dst) || (grant2 && !bus.in2_dst);
    assign load2      = (grant1 &&  bus.in1_dst) || (grant2 &&  bus.in2_dst);
    assign load1_data = (grant1 && !bus.in1_dst) ? bus.in1_data : bus.in2_data;
    assign load2_data = (grant1 &&  bus.in1_dst) ? bus.in1_data : bus.in2_data;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            out1_valid_q <= 1'b0;
            out1_data_q  <= 4'h0;
            out2_valid_q <= 1'b0;
            out2_data_q  <= 4'h0;
            rr           <= 1'b0;
            cnt          <= 8'h00;
        end else begin
            if (load1) begin
                out1_valid_q <= 1'b1;
                out1_data_q  <= load1_data;
            end else if (bus.out1_ready) begin
                out1_valid_q <= 1'b0;
            end

            if (load2) begin
                out2_valid_q <= 1'b1;
                out2_data_q  <= load2_data;
            end else if (bus.out2_ready) begin
                out2_valid_q <= 1'b0;
            end

            if (conflict_grant) begin
                rr <= !rr;
                if (cnt != 8'hFF) cnt <= cnt + 8'h01;
            end
        end
    end

    assign bus.in1_ready    = grant1;
    assign bus.in2_ready    = grant2;
    assign bus.xbar_control = (grant1 && bus.in1_dst) || (grant2 && !bus.in2_dst);
    assign bus.out1_valid   = out1_valid_q;
    assign bus.out1_data    = out1_data_q;
    assign bus.out2_valid   = out2_valid_q;
    assign bus.out2_data    = out2_data_q;
    assign bus.conflict_cnt = cnt;

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Self-checking bench for crossbar_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_crossbar_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    crossbar_arbiter_if bus ();

    crossbar_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what each output slot holds, the priority bit, the count.
    logic       m_valid [2];
    logic [3:0] m_data  [2];
    logic       m_rr;
    int         m_cnt;
    logic       p_valid [2] = '{1'b0, 1'b0};
    logic [3:0] p_data  [2] = '{4'h0, 4'h0};
    logic       p_rr    = 1'b0;
    int         p_cnt   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= '{1'b0, 1'b0};
            m_data  <= '{4'h0, 4'h0};
            m_rr    <= 1'b0;
            m_cnt   <= 0;
        end else begin
            m_valid <= p_valid;
            m_data  <= p_data;
            m_rr    <= p_rr;
            m_cnt   <= p_cnt;
        end
    end

    // Compare process: on each falling edge, derive the grants from the rules
    // (per output, who is asking and may it accept) and check every output.
    always @(negedge clk) begin
        logic       iv [2];
        logic       id [2];
        logic [3:0] idat [2];
        logic       ordy [2];
        logic       e_ready [2];
        logic       e_xbar;
        logic       conflict;
        int         winner;
        int         n_req;

        iv   = '{bus.in1_valid, bus.in2_valid};
        id   = '{bus.in1_dst, bus.in2_dst};
        idat = '{bus.in1_data, bus.in2_data};
        ordy = '{bus.out1_ready, bus.out2_ready};
        e_ready  = '{1'b0, 1'b0};
        e_xbar   = 1'b0;
        conflict = 1'b0;

        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                winner = -1;
                n_req  = 0;
                for (int i = 0; i < 2; i++)
                    if (iv[i] && (int'(id[i]) == k)) n_req++;
                if (!m_valid[k] || ordy[k]) begin
                    if (n_req == 2) begin
                        winner   = m_rr ? 1 : 0;
                        conflict = 1'b1;
                    end else if (n_req == 1) begin
                        winner = (iv[0] && (int'(id[0]) == k)) ? 0 : 1;
                    end
                end
                if (winner >= 0) begin
                    e_ready[winner] = 1'b1;
                    if (winner != k) e_xbar = 1'b1;
                    p_valid[k] = 1'b1;
                    p_data[k]  = idat[winner];
                end else begin
                    p_valid[k] = m_valid[k] && !ordy[k];
                    p_data[k]  = m_data[k];
                end
            end
            p_rr  = m_rr ^ conflict;
            p_cnt = (conflict && m_cnt < 255) ? m_cnt + 1 : m_cnt;
        end else begin
            p_valid = '{1'b0, 1'b0};
            p_data  = '{4'h0, 4'h0};
            p_rr    = 1'b0;
            p_cnt   = 0;
        end

        check("in1_ready",    32'(bus.in1_ready),    32'(e_ready[0]));
        check("in2_ready",    32'(bus.in2_ready),    32'(e_ready[1]));
        check("xbar_control", 32'(bus.xbar_control), 32'(e_xbar));
        check("out1_valid",   32'(bus.out1_valid),   32'(rst_n ? m_valid[0] : 1'b0));
        check("out2_valid",   32'(bus.out2_valid),   32'(rst_n ? m_valid[1] : 1'b0));
        check("conflict_cnt", 32'(bus.conflict_cnt), rst_n ? 32'(m_cnt) : 32'd0);
        // Payload only matters while the slot is full, or under reset.
        if (!rst_n || m_valid[0]) check("out1_data", 32'(bus.out1_data), 32'(rst_n ? m_data[0] : 4'h0));
        if (!rst_n || m_valid[1]) check("out2_data", 32'(bus.out2_data), 32'(rst_n ? m_data[1] : 4'h0));
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic d1, input logic [3:0] x1,
                         input logic v2, input logic d2, input logic [3:0] x2);
        bus.in1_valid = v1; bus.in1_dst = d1; bus.in1_data = x1;
        bus.in2_valid = v2; bus.in2_dst = d2; bus.in2_data = x2;
    endtask

    task automatic do_reset();
        drive(0, 0, 4'h0, 0, 0, 4'h0);
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 0, 4'h0, 0, 0, 4'h0);
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b1;
        #2;
        check("reset out1_valid", 32'(bus.out1_valid), 32'd0);
        check("reset cnt",        32'(bus.conflict_cnt), 32'd0);
        check("reset in1_ready",  32'(bus.in1_ready), 32'd0);
        do_reset();

        // Straight routing.
        drive(1, 0, 4'h3, 1, 1, 4'hA);
        #2;
        check("straight in1_ready", 32'(bus.in1_ready), 32'd1);
        check("straight in2_ready", 32'(bus.in2_ready), 32'd1);
        check("straight xbar",      32'(bus.xbar_control), 32'd0);
        cycle();
        drive(0, 0, 4'h0, 0, 0, 4'h0);
        check("straight out1_data", 32'(bus.out1_data), 32'h3);
        check("straight out2_data", 32'(bus.out2_data), 32'hA);
        check("straight valids",    32'({bus.out1_valid, bus.out2_valid}), 32'b11);

        // Swap routing.
        drive(1, 1, 4'h5, 1, 0, 4'hC);
        #2;
        check("swap xbar", 32'(bus.xbar_control), 32'd1);
        cycle();
        drive(0, 0, 4'h0, 0, 0, 4'h0);
        check("swap out1_data", 32'(bus.out1_data), 32'hC);
        check("swap out2_data", 32'(bus.out2_data), 32'h5);

        // Round-robin conflict on out1.
        do_reset();
        drive(1, 0, 4'h1, 1, 0, 4'h2);
        for (int i = 0; i < 4; i++) begin
            #2;
            check("rr in1_ready", 32'(bus.in1_ready), 32'(i % 2 == 0));
            check("rr in2_ready", 32'(bus.in2_ready), 32'(i % 2 == 1));
            cycle();
            check("rr out1_data", 32'(bus.out1_data), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        check("rr conflict_cnt", 32'(bus.conflict_cnt), 32'd4);

        // Backpressure on out2.
        drive(0, 0, 4'h0, 1, 1, 4'h7);
        bus.out2_ready = 1'b0;
        cycle();
        drive(1, 1, 4'h9, 0, 0, 4'h0);
        #2;
        check("bp in1_ready stall", 32'(bus.in1_ready), 32'd0);
        check("bp out2_data hold",  32'(bus.out2_data), 32'h7);
        cycle();
        check("bp out2_data still", 32'(bus.out2_data), 32'h7);
        bus.out2_ready = 1'b1;
        #1;
        check("bp in1_ready go", 32'(bus.in1_ready), 32'd1);
        cycle();
        drive(0, 0, 4'h0, 0, 0, 4'h0);
        check("bp out2_data new",  32'(bus.out2_data), 32'h9);
        check("bp out2_valid new", 32'(bus.out2_valid), 32'd1);

        // Saturation after 300 conflict grants.
        do_reset();
        drive(1, 1, 4'h4, 1, 1, 4'h8);
        for (int i = 0; i < 300; i++) cycle();
        check("sat conflict_cnt", 32'(bus.conflict_cnt), 32'd255);

        // Asynchronous reset mid-cycle.
        do_reset();
        drive(1, 0, 4'h6, 1, 0, 4'hB);
        bus.out1_ready = 1'b0;
        cycle();
        bus.out1_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check("areset pre cnt",   32'(bus.conflict_cnt), 32'd9);
        check("areset pre valid", 32'(bus.out1_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset out1_valid", 32'(bus.out1_valid), 32'd0);
        check("areset out1_data",  32'(bus.out1_data), 32'h0);
        check("areset cnt",        32'(bus.conflict_cnt), 32'd0);
        check("areset in1_ready",  32'(bus.in1_ready), 32'd0);
        cycle();
        rst_n = 1'b1;
        #1;
        check("post-reset in1_ready", 32'(bus.in1_ready), 32'd1);
        check("post-reset in2_ready", 32'(bus.in2_ready), 32'd0);
        cycle();

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom));
            bus.out1_ready = ($urandom_range(0, 9) < 6);
            bus.out2_ready = ($urandom_range(0, 9) < 6);
            if (i == 1000) begin
                #2;
                rst_n = 1'b0;
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end

        drive(0, 0, 4'h0, 0, 0, 4'h0);
        cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
